// File: rtl/two24_unpack.sv
// two24_unpack: serialises packed TWO24 results onto a 24-bit stream.
// Optional out_ovf_o port when TWO24_UNPACK_OVF_FLAG_EN is defined.
module two24_unpack #(
   parameter bit          SATURATE     = 1'b0,
   parameter int unsigned OVF_CNT_BITS = 16,
   parameter bit          LANE_SWAP    = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [47:0]             in_data_i,
   input  logic [1:0]              in_carry_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [23:0]             out_data_o,
   output logic                    out_last_o,
   input  logic                    ovf_clr_i,
`ifdef TWO24_UNPACK_OVF_FLAG_EN
   output logic [OVF_CNT_BITS-1:0] ovf_count_o,
   output logic                    out_ovf_o
`else
   output logic [OVF_CNT_BITS-1:0] ovf_count_o
`endif
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } state_t;

   state_t state;

   logic        in_acc;
   logic        out_acc;
   logic        load_second;
   logic [23:0] first_raw;
   logic [23:0] second_raw;
   logic        first_c;
   logic        second_c;
   logic [23:0] first_val;
   logic [23:0] second_val;
   logic [23:0] hold_data;

   logic [1:0]              inc;
   logic [OVF_CNT_BITS-1:0] cnt_base;
   logic [OVF_CNT_BITS:0]   cnt_sum;

   // Ready depends on state; in SECOND it follows downstream ready
   always_comb begin
      in_ready_o = 1'b0;
      unique case (state)
         EMPTY:   in_ready_o = 1'b1;
         FIRST:   in_ready_o = 1'b0;
         SECOND:  in_ready_o = out_ready_i;
         default: in_ready_o = 1'b0;
      endcase
   end

   assign in_acc      = in_valid_i && in_ready_o;
   assign out_acc     = out_valid_o && out_ready_i;
   assign load_second = (state == FIRST) && out_acc;

   // Lane ordering and per-lane saturation, resolved at accept time
   always_comb begin
      first_raw  = LANE_SWAP ? in_data_i[47:24] : in_data_i[23:0];
      second_raw = LANE_SWAP ? in_data_i[23:0]  : in_data_i[47:24];
      first_c    = LANE_SWAP ? in_carry_i[1]    : in_carry_i[0];
      second_c   = LANE_SWAP ? in_carry_i[0]    : in_carry_i[1];
      first_val  = (SATURATE && first_c)  ? 24'hFFFFFF : first_raw;
      second_val = (SATURATE && second_c) ? 24'hFFFFFF : second_raw;
   end

   // Output FSM: registered sample, last flag and held second lane
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= EMPTY;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         hold_data   <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_acc) begin
                  out_data_o  <= first_val;
                  out_last_o  <= 1'b0;
                  out_valid_o <= 1'b1;
                  hold_data   <= second_val;
                  state       <= FIRST;
               end
            end
            FIRST: begin
               if (out_acc) begin
                  out_data_o <= hold_data;
                  out_last_o <= 1'b1;
                  state      <= SECOND;
               end
            end
            SECOND: begin
               if (out_acc) begin
                  if (in_acc) begin
                     out_data_o <= first_val;
                     out_last_o <= 1'b0;
                     hold_data  <= second_val;
                     state      <= FIRST;
                  end else begin
                     out_valid_o <= 1'b0;
                     state       <= EMPTY;
                  end
               end
            end
            default: begin
               out_valid_o <= 1'b0;
               state       <= EMPTY;
            end
         endcase
      end
   end

`ifdef TWO24_UNPACK_OVF_FLAG_EN
   logic hold_c;

   // Carry flag travels with the lane currently on out_data_o
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_ovf_o <= 1'b0;
         hold_c    <= 1'b0;
      end else if (in_acc) begin
         out_ovf_o <= first_c;
         hold_c    <= second_c;
      end else if (load_second) begin
         out_ovf_o <= hold_c;
      end
   end
`endif

   always_comb begin
      inc      = {1'b0, in_carry_i[1]} + {1'b0, in_carry_i[0]};
      cnt_base = ovf_clr_i ? '0 : ovf_count_o;
      cnt_sum  = {1'b0, cnt_base} + (OVF_CNT_BITS+1)'(inc);
   end

   // Saturating overflow counter: clear first, then add this accept
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_count_o <= '0;
      end else if (in_acc) begin
         if (cnt_sum[OVF_CNT_BITS])
            ovf_count_o <= '1;
         else
            ovf_count_o <= cnt_sum[OVF_CNT_BITS-1:0];
      end else if (ovf_clr_i) begin
         ovf_count_o <= '0;
      end
   end

endmodule
